// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and publishes difference, unsigned borrow-out and signed overflow together
// with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// SHIFT | one full-subtractor bit per edge, busy=1
// DONE  | one-cycle done pulse, then back to IDLE unconditionally
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic             br_q,     br_d;
    logic [WIDTH-1:0] d_q,      d_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;

    logic             diff_bit;
    logic             br_next;
    logic [WIDTH-1:0] acc_shift;

    // Full-subtractor slice on the current LSBs and the running borrow.
    always_comb begin
        diff_bit = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
        br_next  = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    end

    // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    always_comb begin
        acc_shift            = acc_q >> 1;
        acc_shift[WIDTH-1]   = diff_bit;
    end

    // Next-state logic; result registers only change on the final SHIFT edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        br_d    = br_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                br_d   = br_next;
                acc_d  = acc_shift;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // br_q is the borrow into the MSB, br_next the borrow out of it.
                    d_d     = acc_shift;
                    bout_d  = br_next;
                    ovf_d   = br_q ^ br_next;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            br_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            br_q    <= br_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status flags decode directly from the registered state.
    always_comb begin
        busy = (state_q == S_SHIFT);
        done = (state_q == S_DONE);
        d    = d_q;
        bout = bout_q;
        ovf  = ovf_q;
    end

endmodule
